cdcsync_hs_tx: RTL

//  Source-side end of a 4-phase-free, toggle-based req/ack CDC handshake.

---
 rtl/cdcsync_pkg.sv | 8 +
 rtl/cdcsync_l2l.sv | 25 ++
 rtl/cdcsync_hs_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cdcsync_pkg.sv
// Shared types and defaults for the toggle-based req/ack CDC handshake blocks.
package cdcsync_pkg;

  typedef enum logic {IDLE, WAIT_ACK} cdcsync_hs_st_e;

  localparam int CDCSYNC_FLOP_N_DEF = 2;

endpackage

// File: rtl/cdcsync_l2l.sv
// Level-to-level synchronizer: FLOP_N-deep flop chain moving a slow level into des_clk.
module cdcsync_l2l
  import cdcsync_pkg::*;
#(
  parameter int FLOP_N = CDCSYNC_FLOP_N_DEF
) (
  input  logic des_clk,
  input  logic des_rstn,
  input  logic src_lvl,
  output logic des_lvl
);

  logic [FLOP_N-1:0] r_sync;

  always_ff @(posedge des_clk or negedge des_rstn) begin
    if (!des_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[FLOP_N-2:0], src_lvl};
    end
  end

  assign des_lvl = r_sync[FLOP_N-1];

endmodule

// File: rtl/cdcsync_hs_tx.sv
// Source side of a toggle req/ack CDC handshake; holds tx_data and toggles tx_req_lvl per word.
// Optional one-entry pending buffer enabled by defining CDCSYNC_HS_TX_PEND_EN.
module cdcsync_hs_tx
  import cdcsync_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FLOP_N = CDCSYNC_FLOP_N_DEF
) (
  input  logic              src_clk,
  input  logic              src_rstn,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              tx_req_lvl,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack_lvl,
  output logic              busy
);

  cdcsync_hs_st_e    r_state, w_state_next;
  logic              r_req, w_req_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_ready, w_ready_next;
  logic              w_ack_s;
  logic              w_accept;
  logic              w_done;

  cdcsync_l2l #(
    .FLOP_N (FLOP_N)
  ) u_ack_sync (
    .des_clk  (src_clk),
    .des_rstn (src_rstn),
    .src_lvl  (rx_ack_lvl),
    .des_lvl  (w_ack_s)
  );

  assign w_accept = src_valid & r_ready;
  assign w_done   = (r_state == WAIT_ACK) && (w_ack_s == r_req);

`ifdef CDCSYNC_HS_TX_PEND_EN
  logic              r_pend_vld, w_pend_vld_next;
  logic [DATA_W-1:0] r_pend_data, w_pend_data_next;

  // Pending word always leaves before any newer word, so ordering is preserved.
  always_comb begin
    w_state_next     = r_state;
    w_req_next       = r_req;
    w_data_next      = r_data;
    w_pend_vld_next  = r_pend_vld;
    w_pend_data_next = r_pend_data;
    if (w_done) begin
      if (r_pend_vld) begin
        w_data_next     = r_pend_data;
        w_req_next      = ~r_req;
        w_pend_vld_next = 1'b0;
        if (w_accept) begin
          w_pend_data_next = src_data;
          w_pend_vld_next  = 1'b1;
        end
      end else if (w_accept) begin
        w_data_next = src_data;
        w_req_next  = ~r_req;
      end else begin
        w_state_next = IDLE;
      end
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        w_data_next  = src_data;
        w_req_next   = ~r_req;
        w_state_next = WAIT_ACK;
      end else begin
        w_pend_data_next = src_data;
        w_pend_vld_next  = 1'b1;
      end
    end
    w_ready_next = ~w_pend_vld_next;
  end

  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
    end else begin
      r_pend_vld  <= w_pend_vld_next;
      r_pend_data <= w_pend_data_next;
    end
  end
`else
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_data_next  = r_data;
    if (w_done) begin
      w_state_next = IDLE;
    end else if (w_accept && (r_state == IDLE)) begin
      w_data_next  = src_data;
      w_req_next   = ~r_req;
      w_state_next = WAIT_ACK;
    end
    w_ready_next = (w_state_next == IDLE);
  end
`endif

  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_data  <= w_data_next;
      r_ready <= w_ready_next;
    end
  end

  // busy drops as soon as the synced ack matches, one edge before the retire edge.
  assign busy       = (r_state == WAIT_ACK) && (w_ack_s != r_req);
  assign src_ready  = r_ready;
  assign tx_req_lvl = r_req;
  assign tx_data    = r_data;

endmodule
